// File: rtl/axi_sram_pkg.sv
// Shared encodings, FSM state type and response-precedence helper for the
// AXI4-to-SRAM responder.
package axi_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_RD_REQ,
    ST_RD_DATA
  } state_e;

  // DECERR dominates SLVERR, which dominates OKAY.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_sram_addr_gen.sv
// Beat address datapath: alignment, SRAM word address, next-beat address and
// per-beat error classification. Shared by the read and write paths.
module axi_sram_addr_gen
  import axi_sram_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]                size_i,
  input  logic [1:0]                burst_i,
  output logic [MEM_ADDR_WIDTH-1:0] word_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0] next_addr_o,
  output logic [1:0]                beat_resp_o
);

  localparam int OFF = $clog2(AXI_DATA_WIDTH / 8);
  localparam int HI  = MEM_ADDR_WIDTH + OFF;

  logic [AXI_ADDR_WIDTH-1:0] mask;
  logic [AXI_ADDR_WIDTH-1:0] aligned;
  logic [AXI_ADDR_WIDTH-1:0] step;
  logic                      cfg_err;
  logic                      range_err;

  assign mask        = {AXI_ADDR_WIDTH{1'b1}} << size_i;
  assign aligned     = addr_i & mask;
  assign step        = AXI_ADDR_WIDTH'(1) << size_i;
  assign word_addr_o = aligned[HI-1:OFF];

  // Oversized beats and WRAP/reserved bursts are rejected wholesale.
  assign cfg_err   = (size_i > 3'(OFF)) || (burst_i == BURST_WRAP) || (burst_i == 2'd3);
  assign range_err = (aligned >> HI) != '0;

  assign beat_resp_o = resp_merge(cfg_err   ? RESP_SLVERR : RESP_OKAY,
                                  range_err ? RESP_DECERR : RESP_OKAY);

  always_comb begin
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = aligned + step;
      default:     next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 slave terminator driving a single-port SRAM. One transaction at a time,
// read/write arbitration is round-robin between the two request channels.
module axi_sram_responder
  import axi_sram_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 12,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic [1:0]                  aw_burst_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic [2:0]                  ar_size_i,
  input  logic [1:0]                  ar_burst_i,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);

  state_e                    state_q, state_d;
  logic                      prio_q, prio_d;      // 0: write wins a tie, 1: read wins
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [1:0]                wresp_q, wresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      rd_first_q, rd_first_d;

  logic [MEM_ADDR_WIDTH-1:0] word_addr;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;
  logic [1:0]                beat_resp;
  logic                      beat_ok;
  logic                      is_last;
  logic                      aw_win;
  logic                      ar_win;
  logic [AXI_DATA_WIDTH-1:0] rdata_cur;

  axi_sram_addr_gen #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .word_addr_o (word_addr),
    .next_addr_o (next_addr),
    .beat_resp_o (beat_resp)
  );

  assign beat_ok = (beat_resp == RESP_OKAY);
  assign is_last = (cnt_q == len_q);
  assign aw_win  = aw_valid_i && (!ar_valid_i || !prio_q);
  assign ar_win  = ar_valid_i && (!aw_valid_i || prio_q);

  // SRAM data is only live in the first RD_DATA cycle; afterwards the copy holds R stable.
  assign rdata_cur = !beat_ok ? '0 : (rd_first_q ? mem_rdata_i : rdata_q);

  assign b_id_o      = id_q;
  assign b_resp_o    = wresp_q;
  assign r_id_o      = id_q;
  assign r_data_o    = rdata_cur;
  assign r_resp_o    = beat_resp;
  assign r_last_o    = is_last;
  assign mem_addr_o  = word_addr;
  assign mem_wdata_o = w_data_i;

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    wresp_d    = wresp_q;
    rdata_d    = rdata_q;
    rd_first_d = rd_first_q;
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    r_valid_o  = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = '0;

    case (state_q)
      ST_IDLE: begin
        if (aw_win) begin
          aw_ready_o = 1'b1;
          id_d       = aw_id_i;
          addr_d     = aw_addr_i;
          len_d      = aw_len_i;
          size_d     = aw_size_i;
          burst_d    = aw_burst_i;
          cnt_d      = '0;
          wresp_d    = RESP_OKAY;
          state_d    = ST_WRITE;
        end else if (ar_win) begin
          ar_ready_o = 1'b1;
          id_d       = ar_id_i;
          addr_d     = ar_addr_i;
          len_d      = ar_len_i;
          size_d     = ar_size_i;
          burst_d    = ar_burst_i;
          cnt_d      = '0;
          wresp_d    = RESP_OKAY;
          state_d    = ST_RD_REQ;
        end
      end

      ST_WRITE: begin
        w_ready_o = 1'b1;
        if (w_valid_i) begin
          mem_req_o = beat_ok;
          mem_we_o  = 1'b1;
          mem_be_o  = w_strb_i;
          wresp_d   = resp_merge(wresp_q, beat_resp);
          // The beat counter, not w_last, ends the burst; a disagreeing w_last is a protocol error.
          if (w_last_i != is_last) wresp_d = resp_merge(wresp_d, RESP_SLVERR);
          if (is_last) begin
            state_d = ST_WRESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = next_addr;
          end
        end
      end

      ST_WRESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) begin
          state_d = ST_IDLE;
          prio_d  = 1'b1;
        end
      end

      ST_RD_REQ: begin
        mem_req_o  = beat_ok;
        rd_first_d = 1'b1;
        state_d    = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        r_valid_o  = 1'b1;
        rd_first_d = 1'b0;
        if (rd_first_q) rdata_d = rdata_cur;
        if (r_ready_i) begin
          if (is_last) begin
            state_d = ST_IDLE;
            prio_d  = 1'b0;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = next_addr;
            state_d = ST_RD_REQ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of every other register, independent of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      wresp_q    <= '0;
      rdata_q    <= '0;
      rd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      wresp_q    <= wresp_d;
      rdata_q    <= rdata_d;
      rd_first_q <= rd_first_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: a table of write/read bursts with
// hand-computed results, plus arbitration, R-stall and mid-burst reset sequences.
module tb_axi_sram_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 12;
  localparam int MW = 10;

  localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2;
  localparam logic [1:0] OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          aw_valid_i, aw_ready_o;
  logic [IW-1:0] aw_id_i;
  logic [AW-1:0] aw_addr_i;
  logic [7:0]    aw_len_i;
  logic [2:0]    aw_size_i;
  logic [1:0]    aw_burst_i;
  logic          w_valid_i, w_ready_o;
  logic [DW-1:0] w_data_i;
  logic [3:0]    w_strb_i;
  logic          w_last_i;
  logic          b_valid_o, b_ready_i;
  logic [IW-1:0] b_id_o;
  logic [1:0]    b_resp_o;
  logic          ar_valid_i, ar_ready_o;
  logic [IW-1:0] ar_id_i;
  logic [AW-1:0] ar_addr_i;
  logic [7:0]    ar_len_i;
  logic [2:0]    ar_size_i;
  logic [1:0]    ar_burst_i;
  logic          r_valid_o, r_ready_i;
  logic [IW-1:0] r_id_o;
  logic [DW-1:0] r_data_o;
  logic [1:0]    r_resp_o;
  logic          r_last_o;
  logic          mem_req_o, mem_we_o;
  logic [MW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_rdata_i;

  axi_sram_responder #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .AXI_ID_WIDTH   (IW),
    .MEM_ADDR_WIDTH (MW)
  ) dut (
    .clk (clk), .rst (rst),
    .aw_valid_i (aw_valid_i), .aw_ready_o (aw_ready_o), .aw_id_i (aw_id_i),
    .aw_addr_i (aw_addr_i), .aw_len_i (aw_len_i), .aw_size_i (aw_size_i), .aw_burst_i (aw_burst_i),
    .w_valid_i (w_valid_i), .w_ready_o (w_ready_o), .w_data_i (w_data_i),
    .w_strb_i (w_strb_i), .w_last_i (w_last_i),
    .b_valid_o (b_valid_o), .b_ready_i (b_ready_i), .b_id_o (b_id_o), .b_resp_o (b_resp_o),
    .ar_valid_i (ar_valid_i), .ar_ready_o (ar_ready_o), .ar_id_i (ar_id_i),
    .ar_addr_i (ar_addr_i), .ar_len_i (ar_len_i), .ar_size_i (ar_size_i), .ar_burst_i (ar_burst_i),
    .r_valid_o (r_valid_o), .r_ready_i (r_ready_i), .r_id_o (r_id_o), .r_data_o (r_data_o),
    .r_resp_o (r_resp_o), .r_last_o (r_last_o),
    .mem_req_o (mem_req_o), .mem_we_o (mem_we_o), .mem_addr_o (mem_addr_o),
    .mem_wdata_o (mem_wdata_o), .mem_be_o (mem_be_o), .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-enabled writes, read data registered one cycle after the request.
  logic [DW-1:0] mem [1024];
  int            req_cnt = 0;

  always @(posedge clk) begin
    if (mem_req_o) begin
      req_cnt <= req_cnt + 1;
      if (mem_we_o) begin
        for (int i = 0; i < 4; i++)
          if (mem_be_o[i]) mem[mem_addr_o][8*i +: 8] <= mem_wdata_o[8*i +: 8];
      end else begin
        mem_rdata_i <= mem[mem_addr_o];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] dbase;      // write data of beat 0 / expected read data of beat 0
    logic [3:0]  strb;
    int          last_at;    // beat carrying w_last
    logic [1:0]  resp;
    int          reqs;       // expected SRAM requests for the whole burst
    int          step;       // expected word-address step per beat
    int          stall_beat; // read beat held with r_ready low, -1 for none
    int          stall_cyc;
  } vec_t;

  function automatic vec_t mk(bit wr, int id, int addr, int len, int size, logic [1:0] burst,
                              int dbase, int strb, int last_at, logic [1:0] resp, int reqs,
                              int step, int stall_beat, int stall_cyc);
    vec_t v;
    v.wr = wr; v.id = 12'(id); v.addr = addr; v.len = 8'(len); v.size = 3'(size);
    v.burst = burst; v.dbase = dbase; v.strb = 4'(strb); v.last_at = last_at;
    v.resp = resp; v.reqs = reqs; v.step = step; v.stall_beat = stall_beat; v.stall_cyc = stall_cyc;
    return v;
  endfunction

  task automatic wait_ready(input string name, input bit is_aw);
    int t = 0;
    @(negedge clk);
    while (!(is_aw ? aw_ready_o : ar_ready_o) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check(name, is_aw ? aw_ready_o : ar_ready_o, 1);
  endtask

  task automatic run_write(input vec_t v);
    int t;
    int reqs0;
    aw_valid_i = 1'b1; aw_id_i = v.id; aw_addr_i = v.addr;
    aw_len_i = v.len; aw_size_i = v.size; aw_burst_i = v.burst;
    wait_ready("aw_ready", 1'b1);
    @(posedge clk); #1;
    aw_valid_i = 1'b0;
    reqs0 = req_cnt;
    for (int b = 0; b <= int'(v.len); b++) begin
      w_valid_i = 1'b1;
      w_data_i  = v.dbase + 32'(b);
      w_strb_i  = v.strb;
      w_last_i  = (b == v.last_at);
      @(negedge clk);
      check("w_ready", w_ready_o, 1);
      if (v.reqs > 0) check("w_mem_addr", mem_addr_o, 64'((v.addr >> 2) + 32'(b * v.step)));
      @(posedge clk); #1;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0; b_ready_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!b_valid_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("b_valid", b_valid_o, 1);
    check("b_id", b_id_o, v.id);
    check("b_resp", b_resp_o, v.resp);
    @(posedge clk); #1;
    b_ready_i = 1'b0;
    check("w_mem_reqs", req_cnt - reqs0, v.reqs);
  endtask

  task automatic run_read(input vec_t v);
    int t;
    int reqs0;
    int s0;
    logic [31:0] exp;
    ar_valid_i = 1'b1; ar_id_i = v.id; ar_addr_i = v.addr;
    ar_len_i = v.len; ar_size_i = v.size; ar_burst_i = v.burst;
    wait_ready("ar_ready", 1'b0);
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
    reqs0 = req_cnt;
    for (int b = 0; b <= int'(v.len); b++) begin
      r_ready_i = (b != v.stall_beat);
      t = 0;
      @(negedge clk);
      while (!r_valid_o && t < 10) begin
        @(negedge clk);
        t++;
      end
      check("r_wait_cycles", t, 1);
      exp = (v.resp == OKAY) ? v.dbase + 32'(b) : 32'h0;
      check("r_data", r_data_o, exp);
      check("r_id", r_id_o, v.id);
      check("r_resp", r_resp_o, v.resp);
      check("r_last", r_last_o, b == int'(v.len));
      if (b == v.stall_beat) begin
        s0 = req_cnt;
        repeat (v.stall_cyc) begin
          @(posedge clk);
          @(negedge clk);
          check("stall_r_valid", r_valid_o, 1);
          check("stall_r_data", r_data_o, exp);
        end
        check("stall_mem_reqs", req_cnt - s0, 0);
        r_ready_i = 1'b1;
      end
      @(posedge clk); #1;
    end
    r_ready_i = 1'b0;
    check("r_mem_reqs", req_cnt - reqs0, v.reqs);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem_rdata_i = '0;
    aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0; aw_burst_i = 0;
    w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0; b_ready_i = 0;
    ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0; ar_burst_i = 0;
    r_ready_i = 0;

    //                wr id  addr     len sz burst  dbase         strb last resp    reqs stp stall cyc
    vecs[0]  = mk(1, 5,  32'h10,   3, 2, INCR,  32'hA0,       4'hF, 3,  OKAY,   4,   1, -1, 0);
    vecs[1]  = mk(0, 7,  32'h10,   3, 2, INCR,  32'hA0,       4'hF, 3,  OKAY,   4,   1, -1, 0);
    vecs[2]  = mk(0, 7,  32'h10,   3, 2, INCR,  32'hA0,       4'hF, 3,  OKAY,   4,   1,  1, 5);
    vecs[3]  = mk(0, 1,  32'h1000, 1, 2, INCR,  32'h0,        4'hF, 1,  DECERR, 0,   1, -1, 0);
    vecs[4]  = mk(1, 2,  32'h0,    1, 2, WRAP,  32'hC0,       4'hF, 1,  SLVERR, 0,   1, -1, 0);
    vecs[5]  = mk(1, 3,  32'h40,   2, 2, INCR,  32'hB0,       4'hF, 1,  SLVERR, 3,   1, -1, 0);
    vecs[6]  = mk(0, 3,  32'h40,   2, 2, INCR,  32'hB0,       4'hF, 2,  OKAY,   3,   1, -1, 0);
    vecs[7]  = mk(1, 4,  32'h20,   1, 2, FIXED, 32'hD0,       4'hF, 1,  OKAY,   2,   0, -1, 0);
    vecs[8]  = mk(0, 4,  32'h20,   0, 2, INCR,  32'hD1,       4'hF, 0,  OKAY,   1,   1, -1, 0);
    vecs[9]  = mk(1, 6,  32'h10,   0, 2, INCR,  32'h11223344, 4'h3, 0,  OKAY,   1,   1, -1, 0);
    vecs[10] = mk(0, 6,  32'h10,   0, 2, INCR,  32'h00003344, 4'hF, 0,  OKAY,   1,   1, -1, 0);
    vecs[11] = mk(0, 8,  32'h10,   0, 3, INCR,  32'h0,        4'hF, 0,  SLVERR, 0,   1, -1, 0);
    vecs[12] = mk(1, 9,  32'h10,   0, 2, 2'd3,  32'hE0,       4'hF, 0,  SLVERR, 0,   1, -1, 0);
    vecs[13] = mk(0, 9,  32'h10,   0, 2, INCR,  32'h00003344, 4'hF, 0,  OKAY,   1,   1, -1, 0);

    do_reset();
    @(negedge clk);
    check("rst_aw_ready", aw_ready_o, 0);
    check("rst_ar_ready", ar_ready_o, 0);
    check("rst_w_ready", w_ready_o, 0);
    check("rst_b_valid", b_valid_o, 0);
    check("rst_r_valid", r_valid_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) run_write(vecs[i]);
      else            run_read(vecs[i]);
    end

    // Arbitration: simultaneous AW/AR after reset goes to the write, then to the read.
    do_reset();
    aw_valid_i = 1; aw_id_i = 12'd10; aw_addr_i = 32'h80; aw_len_i = 0; aw_size_i = 2; aw_burst_i = INCR;
    ar_valid_i = 1; ar_id_i = 12'd11; ar_addr_i = 32'h80; ar_len_i = 0; ar_size_i = 2; ar_burst_i = INCR;
    @(negedge clk);
    check("arb1_aw_ready", aw_ready_o, 1);
    check("arb1_ar_ready", ar_ready_o, 0);
    @(posedge clk); #1;
    aw_valid_i = 0;
    w_valid_i = 1; w_data_i = 32'h55; w_strb_i = 4'hF; w_last_i = 1;
    @(negedge clk);
    check("arb1_ar_blocked", ar_ready_o, 0);
    @(posedge clk); #1;
    w_valid_i = 0; w_last_i = 0; b_ready_i = 1;
    @(negedge clk);
    check("arb1_b_valid", b_valid_o, 1);
    check("arb1_b_resp", b_resp_o, OKAY);
    @(posedge clk); #1;
    b_ready_i = 0;
    aw_valid_i = 1;
    @(negedge clk);
    check("arb2_ar_ready", ar_ready_o, 1);
    check("arb2_aw_ready", aw_ready_o, 0);
    @(posedge clk); #1;
    ar_valid_i = 0; aw_valid_i = 0; r_ready_i = 1;
    repeat (2) @(negedge clk);
    check("arb2_r_valid", r_valid_o, 1);
    check("arb2_r_data", r_data_o, 32'h55);
    check("arb2_r_id", r_id_o, 12'd11);
    @(posedge clk); #1;
    r_ready_i = 0;

    // Reset while beat 2 of a 4-beat read is in flight.
    ar_valid_i = 1; ar_id_i = 12'd12; ar_addr_i = 32'h10; ar_len_i = 3; ar_size_i = 2; ar_burst_i = INCR;
    wait_ready("mid_ar_ready", 1'b0);
    @(posedge clk); #1;
    ar_valid_i = 0; r_ready_i = 1;
    for (int b = 0; b < 2; b++) begin
      repeat (2) @(negedge clk);
      check("mid_r_valid", r_valid_o, 1);
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; r_ready_i = 0;
    @(negedge clk);
    check("mid_rst_r_valid", r_valid_o, 0);
    check("mid_rst_b_valid", b_valid_o, 0);
    check("mid_rst_w_ready", w_ready_o, 0);
    check("mid_rst_mem_req", mem_req_o, 0);
    check("mid_rst_aw_ready", aw_ready_o, 0);
    check("mid_rst_ar_ready", ar_ready_o, 0);
    @(posedge clk); #1;
    run_read(vecs[13]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI4 slave-side terminator: accepts AW/W/AR from a crossbar master port and returns B/R.
- Drives a single-port SRAM request interface, so on-chip memories hang directly off node master ports.
- Serves one transaction at a time; reads and writes are arbitrated round-robin.

Parameters:
AXI_ADDR_WIDTH, 32, byte address width
AXI_DATA_WIDTH, 32, data width; power of two, >=32
AXI_ID_WIDTH, 12, ID width (node output ID width)
MEM_ADDR_WIDTH, 10, SRAM word-address width

Ports:
clk  in  1  clock
rst  in  1  reset
aw_valid_i / aw_ready_o  in/out  1  AW handshake
aw_id_i  in  AXI_ID_WIDTH  write ID
aw_addr_i  in  AXI_ADDR_WIDTH  write start byte address
aw_len_i  in  8  write beats-1
aw_size_i  in  3  write beat size
aw_burst_i  in  2  write burst type
w_valid_i / w_ready_o  in/out  1  W handshake
w_data_i  in  AXI_DATA_WIDTH  write data
w_strb_i  in  AXI_DATA_WIDTH/8  write strobes
w_last_i  in  1  last write beat
b_valid_o / b_ready_i  out/in  1  B handshake
b_id_o  out  AXI_ID_WIDTH  response ID
b_resp_o  out  2  write response
ar_valid_i / ar_ready_o  in/out  1  AR handshake
ar_id_i  in  AXI_ID_WIDTH  read ID
ar_addr_i  in  AXI_ADDR_WIDTH  read start byte address
ar_len_i  in  8  read beats-1
ar_size_i  in  3  read beat size
ar_burst_i  in  2  read burst type
r_valid_o / r_ready_i  out/in  1  R handshake
r_id_o  out  AXI_ID_WIDTH  read ID
r_data_o  out  AXI_DATA_WIDTH  read data
r_resp_o  out  2  read response
r_last_o  out  1  last read beat
mem_req_o / mem_we_o  out  1  SRAM request / write enable
mem_addr_o  out  MEM_ADDR_WIDTH  SRAM word address
mem_wdata_o / mem_be_o  out  AXI_DATA_WIDTH / AXI_DATA_WIDTH/8  SRAM write data / byte enables
mem_rdata_i  in  AXI_DATA_WIDTH  SRAM read data, valid exactly 1 cycle after a read request

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high. rst=1 at a clock edge returns the FSM to IDLE and clears all *_valid_o, *_ready_o and mem_req_o, plus all registered fields, to 0. In-flight bursts are dropped without a response.
- Defaults: lock/cache/prot/qos/region/user are not ported; the SRAM always grants.
- FSM states: IDLE, WRITE, WRESP, RD_REQ, RD_DATA.
- IDLE arbitration:
  - aw_ready_o/ar_ready_o are asserted combinationally for the winner only.
  - Winner is a single pending request, or on a tie the type not served last (prio flag, reset = write first).
  - The handshake latches ID, address, len, size and burst, clears the beat counter and the error flag, and moves to WRITE or RD_REQ.
- Address generation:
  - Beat address is aligned down to 2^size.
  - INCR adds 2^size bytes per beat. FIXED holds the address.
  - Word address = byte_addr[MEM_ADDR_WIDTH+log2(AXI_DATA_WIDTH/8)-1 : log2(AXI_DATA_WIDTH/8)].
- Error responses:
  - size > log2(AXI_DATA_WIDTH/8), WRAP or burst=3: SLVERR on every beat, no SRAM access.
  - A beat whose byte address has any bit set above the word-address range: DECERR, no SRAM access.
- WRITE:
  - w_ready_o=1.
  - Each W handshake issues mem_req_o=1, mem_we_o=1 and mem_be_o=w_strb_i in the same cycle; for an error beat the SRAM access is suppressed and the beat is still consumed.
  - Throughput: 1 beat/cycle.
  - The burst ends on the beat counter (count==len), not on w_last_i. If w_last_i differs from (count==len) on any beat, the response is SLVERR.
  - Move to WRESP after the final beat.
- WRESP: b_valid_o=1 with the latched ID and resp. Response precedence: DECERR > SLVERR > OKAY. Hold until b_ready_i, then go to IDLE and set prio=read.
- RD_REQ: mem_req_o=1, mem_we_o=0 for one cycle (none for an error beat), then RD_DATA.
- RD_DATA:
  - r_valid_o=1; r_data_o is the SRAM data captured in a register on the first RD_DATA cycle, or 0 for error beats.
  - r_last_o=(count==len).
  - All R outputs hold stable while r_ready_i=0.
  - On handshake: if last, go to IDLE and set prio=write; else increment the address and go to RD_REQ.
  - Read latency is 2 cycles from AR handshake to first r_valid_o; sustained rate is 1 beat per 2 cycles.
- Beat counter: 8 bit, never wraps (len <= 255).

Decomposition:
- Package axi_sram_pkg holds:
  - burst encodings (FIXED=0, INCR=1, WRAP=2);
  - resp encodings (OKAY=0, SLVERR=2, DECERR=3);
  - state enum;
  - function resp_merge for response precedence.
- Sub-module axi_sram_addr_gen: combinational aligned/next-address computation plus range and size check; instantiated once and shared by read and write.

Test Plan:
1. AW id=5 addr=0x10 len=3 size=2 INCR, data 0xA0..0xA3, strb=0xF -> mem_addr 4,5,6,7 on consecutive cycles; B id=5 OKAY. Then AR id=7 same burst -> R 0xA0..0xA3, id=7, r_last on beat 3 only.
2. Same read with r_ready_i low for 5 cycles on beat 1 -> r_data stable at 0xA1, no extra mem_req, sequence unchanged.
3. aw_valid and ar_valid rise together after reset -> write served first; repeat -> read served first.
4. AR addr=0x1000 (word 1024) len=1 -> two R beats DECERR, data 0, zero mem_req; write burst=WRAP len=1 -> both W beats accepted, B SLVERR, zero mem_req.
5. W burst len=2 with w_last on beat 1 -> three beats consumed, B SLVERR.
6. rst=1 during beat 2 of a 4-beat read -> next cycle all valid/ready/mem_req are 0, FSM in IDLE; a new AR is then accepted normally.
